// File: rtl/bn_channel_sequencer_pkg.sv
// bn_seq_pkg: FSM states and ROM word layout shared by the BN channel sequencer.
package bn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Word index (1-based, counted from the LSB) of the top of each field in param_rdata.
    localparam int MEAN_HI  = 4;
    localparam int VAR_HI   = 3;
    localparam int GAMMA_HI = 2;
    localparam int BETA_HI  = 1;

    function automatic int word_msb(input int hi, input int width);
        return hi * width - 1;
    endfunction

endpackage

// File: rtl/bn_channel_sequencer_if.sv
// bn_channel_sequencer_if: control, activation, ROM, BN-unit and tagged-output signals of the sequencer.
interface bn_channel_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 4
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         param_addr;
    logic                    param_rd_en;
    logic [4*DATA_WIDTH-1:0] param_rdata;
    logic [DATA_WIDTH-1:0]   bn_in_data;
    logic                    bn_in_valid;
    logic [DATA_WIDTH-1:0]   bn_mean;
    logic [DATA_WIDTH-1:0]   bn_variance;
    logic [DATA_WIDTH-1:0]   bn_gamma;
    logic [DATA_WIDTH-1:0]   bn_beta;
    logic [DATA_WIDTH-1:0]   bn_out_data;
    logic                    bn_out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic [CH_W-1:0]         out_channel;
    logic                    out_last_pix;
    logic                    out_last;

    modport master (
        input  start, in_data, in_valid, param_rdata, bn_out_data, bn_out_valid,
        output busy, done, in_ready, param_addr, param_rd_en, bn_in_data, bn_in_valid,
               bn_mean, bn_variance, bn_gamma, bn_beta,
               out_data, out_valid, out_channel, out_last_pix, out_last
    );

    modport slave (
        output start, in_data, in_valid, param_rdata, bn_out_data, bn_out_valid,
        input  busy, done, in_ready, param_addr, param_rd_en, bn_in_data, bn_in_valid,
               bn_mean, bn_variance, bn_gamma, bn_beta,
               out_data, out_valid, out_channel, out_last_pix, out_last
    );

endinterface

// File: rtl/bn_channel_sequencer_tagger.sv
// bn_out_tagger: tracks channel/pixel position of BN results and signals when a whole frame has come out.
module bn_out_tagger #(
    parameter int NUM_CHANNELS  = 16,
    parameter int PIXELS_PER_CH = 49,
    parameter int CH_W          = $clog2(NUM_CHANNELS),
    parameter int PIX_W         = $clog2(PIXELS_PER_CH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            valid,
    output logic [CH_W-1:0] out_ch,
    output logic            last_pix,
    output logic            last,
    output logic            frame_done
);

    localparam int TOTAL = NUM_CHANNELS * PIXELS_PER_CH;
    localparam int CNT_W = $clog2(TOTAL + 1);

    logic [PIX_W-1:0] out_pix;
    logic [CNT_W-1:0] out_cnt;
    logic             adv;

    // A result arriving after the frame total is dropped so the counters never wrap into a bogus frame.
    assign adv        = valid && out_cnt != CNT_W'(TOTAL);
    assign last_pix   = out_pix == PIX_W'(PIXELS_PER_CH - 1);
    assign last       = last_pix && out_ch == CH_W'(NUM_CHANNELS - 1);
    assign frame_done = out_cnt == CNT_W'(TOTAL) || (adv && out_cnt == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ch  <= '0;
            out_pix <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            out_ch  <= '0;
            out_pix <= '0;
            out_cnt <= '0;
        end else if (adv) begin
            out_pix <= last_pix ? '0 : out_pix + 1'b1;
            out_ch  <= last_pix ? (last ? '0 : out_ch + 1'b1) : out_ch;
            out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bn_channel_sequencer.sv
// bn_channel_sequencer: streams a channel-major tensor into the BN unit, loading each channel's
// parameters from ROM first, and tags BN results with channel / last-sample flags.
module bn_channel_sequencer
    import bn_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 16,
    parameter int PIXELS_PER_CH = 49,
    parameter int BN_LATENCY    = 3,
    parameter int CH_W          = $clog2(NUM_CHANNELS),
    parameter int PIX_W         = $clog2(PIXELS_PER_CH + 1)
) (
    input logic                     clk,
    input logic                     rst,
    bn_channel_sequencer_if.master  bus
);

    localparam int MEAN_MSB  = word_msb(MEAN_HI, DATA_WIDTH);
    localparam int VAR_MSB   = word_msb(VAR_HI, DATA_WIDTH);
    localparam int GAMMA_MSB = word_msb(GAMMA_HI, DATA_WIDTH);
    localparam int BETA_MSB  = word_msb(BETA_HI, DATA_WIDTH);

    state_t                state, state_nxt;
    logic [CH_W-1:0]       ch;
    logic [PIX_W-1:0]      pix;
    logic [DATA_WIDTH-1:0] mean_q, var_q, gamma_q, beta_q;
    logic                  accept, last_pix, last_ch, frame_start;
    logic [CH_W-1:0]       t_ch;
    logic                  t_last_pix, t_last, frame_out_done;
    logic [BN_LATENCY-1:0] in_hist;

    assign last_pix    = pix == PIX_W'(PIXELS_PER_CH - 1);
    assign last_ch     = ch == CH_W'(NUM_CHANNELS - 1);
    assign frame_start = state == S_IDLE && bus.start;

    always_comb begin
        state_nxt       = state;
        accept          = state == S_STREAM && bus.in_valid;
        bus.busy        = state != S_IDLE;
        bus.done        = state == S_DONE;
        bus.in_ready    = state == S_STREAM;
        bus.param_rd_en = state == S_FETCH;
        bus.param_addr  = state == S_FETCH ? ch : '0;
        bus.bn_in_valid = accept;
        bus.bn_in_data  = bus.in_data;
        unique case (state)
            S_IDLE:   state_nxt = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_STREAM;
            S_STREAM: state_nxt = accept && last_pix ? (last_ch ? S_DRAIN : S_FETCH) : S_STREAM;
            S_DRAIN:  state_nxt = frame_out_done ? S_DONE : S_DRAIN;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ch    <= '0;
            pix   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                ch  <= '0;
                pix <= '0;
            end else if (accept) begin
                pix <= last_pix ? '0 : pix + 1'b1;
                ch  <= last_pix ? (last_ch ? '0 : ch + 1'b1) : ch;
            end
        end
    end

    // ROM data is valid the cycle after the FETCH strobe, which is exactly the LOAD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean_q  <= '0;
            var_q   <= '0;
            gamma_q <= '0;
            beta_q  <= '0;
        end else if (state == S_LOAD) begin
            mean_q  <= bus.param_rdata[MEAN_MSB -: DATA_WIDTH];
            var_q   <= bus.param_rdata[VAR_MSB -: DATA_WIDTH];
            gamma_q <= bus.param_rdata[GAMMA_MSB -: DATA_WIDTH];
            beta_q  <= bus.param_rdata[BETA_MSB -: DATA_WIDTH];
        end
    end

    assign bus.bn_mean     = mean_q;
    assign bus.bn_variance = var_q;
    assign bus.bn_gamma    = gamma_q;
    assign bus.bn_beta     = beta_q;

    // frame_done looks through the final result so DONE follows the last output by one cycle.
    bn_out_tagger #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PIXELS_PER_CH(PIXELS_PER_CH),
        .CH_W         (CH_W),
        .PIX_W        (PIX_W)
    ) u_tagger (
        .clk       (clk),
        .rst       (rst),
        .clr       (frame_start),
        .valid     (bus.bn_out_valid),
        .out_ch    (t_ch),
        .last_pix  (t_last_pix),
        .last      (t_last),
        .frame_done(frame_out_done)
    );

    assign bus.out_valid    = bus.bn_out_valid;
    assign bus.out_data     = bus.bn_out_data;
    assign bus.out_channel  = bus.bn_out_valid ? t_ch : '0;
    assign bus.out_last_pix = bus.bn_out_valid && t_last_pix;
    assign bus.out_last     = bus.bn_out_valid && t_last;

    // The BN unit is a fixed-latency pipeline; a mismatch means BN_LATENCY is misconfigured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_hist <= '0;
        end else begin
            in_hist <= BN_LATENCY'({in_hist, accept});
            assert (bus.bn_out_valid == in_hist[BN_LATENCY-1]);
        end
    end

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// tb_bn_channel_sequencer: directed table plus multi-cycle sequences against a ROM and a
// 3-stage BN pipeline model (result = sample + channel mean).
module tb_bn_channel_sequencer;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bn_channel_sequencer_if #(.DATA_WIDTH(DW), .CH_W(1)) bus();

    bn_channel_sequencer #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (2),
        .PIXELS_PER_CH(4),
        .BN_LATENCY   (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk)
        if (bus.param_rd_en)
            bus.param_rdata <= bus.param_addr ? {16'h20, 16'h10, 16'h10, 16'h0}
                                              : {16'h00, 16'h10, 16'h10, 16'h0};

    logic [DW-1:0] d1, d2, d3;
    logic          v1, v2, v3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {v1, v2, v3} <= '0;
            d1 <= '0; d2 <= '0; d3 <= '0;
        end else begin
            v1 <= bus.bn_in_valid;
            d1 <= bus.bn_in_valid ? bus.bn_in_data + bus.bn_mean : '0;
            v2 <= v1; d2 <= d1;
            v3 <= v2; d3 <= d2;
        end
    end
    assign bus.bn_out_valid = v3;
    assign bus.bn_out_data  = d3;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] flags_now();
        return {bus.busy, bus.in_ready, bus.bn_in_valid, bus.param_rd_en, bus.param_addr,
                bus.done, bus.out_valid, bus.out_channel, bus.out_last_pix, bus.out_last};
    endfunction

    function automatic logic [63:0] params_now();
        return {bus.bn_mean, bus.bn_variance, bus.bn_gamma, bus.bn_beta};
    endfunction

    function automatic logic [15:0] chmean(input int c);
        return c == 1 ? 16'h20 : 16'h0;
    endfunction

    // flags: busy,in_ready,bn_in_valid,rd_en,addr,done,out_valid,out_channel,out_last_pix,out_last
    typedef struct {
        logic       start;
        logic       in_valid;
        logic [9:0] flags;
        logic [15:0] mean;
        logic [15:0] odata;
    } vec_t;

    vec_t tbl[18];

    task automatic run_frame(input bit kick, input bit bubble, input bit poke);
        logic [15:0] q[$];
        int acc = 0, oc = 0, fetches = 0, gap = 0, last_acc = -100, last_out = -100;
        bit gap_seen = 0, got_done = 0;
        if (kick) begin
            @(negedge clk);
            bus.start = 1'b1; bus.in_valid = 1'b0;
            #1 chk("kick_idle_busy", bus.busy, 0);
        end
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            bus.start    = poke && cyc == 10;
            bus.in_valid = bubble ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = 16'h200 + 16'(cyc);
            #1;
            if (!bus.in_valid) chk("bn_in_valid_in_gap", bus.bn_in_valid, 0);
            if (bus.param_rd_en) begin
                chk("fetch_addr", bus.param_addr, fetches);
                fetches++;
            end
            if (bus.in_ready)
                chk("params_stable", params_now(), {chmean(acc / 4), 16'h10, 16'h10, 16'h0});
            if (acc == 4 && !gap_seen) begin
                if (bus.in_ready) begin
                    chk("ch_switch_gap", gap, 2);
                    gap_seen = 1;
                end else gap++;
            end
            if (bus.bn_in_valid) begin
                q.push_back(bus.in_data + chmean(acc / 4));
                acc++;
                last_acc = cyc;
            end
            if (bus.out_valid) begin
                chk($sformatf("out_channel_%0d", oc), bus.out_channel, oc / 4);
                chk($sformatf("out_last_pix_%0d", oc), bus.out_last_pix, oc % 4 == 3);
                chk($sformatf("out_last_%0d", oc), bus.out_last, oc == 7);
                chk("out_pending", q.size() > 0, 1);
                if (q.size() > 0) chk($sformatf("out_data_%0d", oc), bus.out_data, q.pop_front());
                oc++;
                last_out = cyc;
            end
            if (bus.done) begin
                got_done = 1;
                chk("frame_accepts", acc, 8);
                chk("frame_outputs", oc, 8);
                chk("frame_fetches", fetches, 2);
                chk("drain_cycles", cyc - last_acc, LAT + 1);
                chk("done_after_last_out", cyc - last_out, 1);
            end
        end
        if (!got_done) chk("frame_timeout", got_done, 1);
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        #1 chk("idle_after_done", {bus.busy, bus.done}, 0);
    endtask

    initial begin
        int racc;
        tbl[0]  = '{1'b1, 1'b1, 10'b0000000000, 16'h00, 16'h000};
        tbl[1]  = '{1'b0, 1'b1, 10'b1001000000, 16'h00, 16'h000};
        tbl[2]  = '{1'b0, 1'b1, 10'b1000000000, 16'h00, 16'h000};
        tbl[3]  = '{1'b0, 1'b1, 10'b1110000000, 16'h00, 16'h000};
        tbl[4]  = '{1'b0, 1'b1, 10'b1110000000, 16'h00, 16'h000};
        tbl[5]  = '{1'b0, 1'b1, 10'b1110000000, 16'h00, 16'h000};
        tbl[6]  = '{1'b0, 1'b1, 10'b1110001000, 16'h00, 16'h103};
        tbl[7]  = '{1'b0, 1'b1, 10'b1001101000, 16'h00, 16'h104};
        tbl[8]  = '{1'b0, 1'b1, 10'b1000001000, 16'h00, 16'h105};
        tbl[9]  = '{1'b0, 1'b1, 10'b1110001010, 16'h20, 16'h106};
        tbl[10] = '{1'b0, 1'b1, 10'b1110000000, 16'h20, 16'h000};
        tbl[11] = '{1'b0, 1'b1, 10'b1110000000, 16'h20, 16'h000};
        tbl[12] = '{1'b0, 1'b1, 10'b1110001100, 16'h20, 16'h129};
        tbl[13] = '{1'b0, 1'b1, 10'b1000001100, 16'h20, 16'h12A};
        tbl[14] = '{1'b0, 1'b1, 10'b1000001100, 16'h20, 16'h12B};
        tbl[15] = '{1'b0, 1'b1, 10'b1000001111, 16'h20, 16'h12C};
        tbl[16] = '{1'b0, 1'b1, 10'b1000010000, 16'h20, 16'h000};
        tbl[17] = '{1'b1, 1'b1, 10'b0000000000, 16'h20, 16'h000};

        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_flags", flags_now(), 0);
        chk("reset_params", params_now(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame with in_valid held high; the last row restarts right after done.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus.start    = tbl[i].start;
            bus.in_valid = tbl[i].in_valid;
            bus.in_data  = 16'h100 + 16'(i);
            #1;
            chk($sformatf("row%0d", i), {flags_now(), bus.bn_mean, bus.out_data},
                {tbl[i].flags, tbl[i].mean, tbl[i].odata});
        end

        // Back-to-back frame with input bubbles and a start pulse while busy.
        run_frame(1'b0, 1'b1, 1'b1);

        // Reset in the middle of a frame after three accepted samples.
        racc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b0;
        for (int c = 0; c < 20 && racc < 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h300;
            #1;
            if (bus.bn_in_valid) racc++;
        end
        chk("pre_reset_accepts", racc, 3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_reset_flags", flags_now(), 0);
        chk("mid_reset_params", params_now(), 0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_channel_sequencer.md
Name: bn_channel_sequencer

Overview:
- Controls the per-channel BatchNorm datapath in the SE layer.
- Streams a channel-major activation tensor (PIXELS_PER_CH samples per channel, NUM_CHANNELS channels) into the BN unit.
- Fetches each channel's {mean, variance, gamma, beta} from a parameter ROM and holds them stable for that channel.
- Tags BN outputs with channel index and last flags, and reports completion.

Parameters:
- DATA_WIDTH, 16, activation and parameter word width.
- NUM_CHANNELS, 16, channels per frame.
- PIXELS_PER_CH, 49, samples per channel.
- BN_LATENCY, 3, cycles from bn_in_valid to bn_out_valid.
- CH_W, $clog2(NUM_CHANNELS), channel index width.
- PIX_W, $clog2(PIXELS_PER_CH+1), pixel counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one frame; ignored unless idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last BN output.
- in_data  in  DATA_WIDTH  activation sample.
- in_valid  in  1  sample present.
- in_ready  out  1  sequencer accepts sample.
- param_addr  out  CH_W  ROM address (channel).
- param_rd_en  out  1  ROM read strobe.
- param_rdata  in  4*DATA_WIDTH  {mean, variance, gamma, beta}, MSB first; valid 1 cycle after param_rd_en.
- bn_in_data  out  DATA_WIDTH  to BN unit.
- bn_in_valid  out  1  to BN unit.
- bn_mean, bn_variance, bn_gamma, bn_beta  out  DATA_WIDTH each  held channel parameters.
- bn_out_data  in  DATA_WIDTH  from BN unit.
- bn_out_valid  in  1  from BN unit.
- out_data  out  DATA_WIDTH  normalized result.
- out_valid  out  1  result strobe.
- out_channel  out  CH_W  channel of current result.
- out_last_pix  out  1  last sample of channel.
- out_last  out  1  last sample of frame.

Behaviour:
- Reset (any time, including mid-frame): state IDLE; all counters 0; param registers 0; all outputs 0. Samples in flight in the BN unit are discarded.
- FSM states: IDLE, FETCH, LOAD, STREAM, DRAIN, DONE.
- IDLE: start=1 -> FETCH with ch=0. start during any other state is ignored.
- FETCH, one cycle: param_rd_en=1, param_addr=ch. -> LOAD.
- LOAD, one cycle: capture param_rdata into the bn_* registers. -> STREAM.
- Channel-switch overhead is exactly 2 cycles with in_ready=0.
- STREAM: in_ready=1.
  - bn_in_valid = in_valid & in_ready (combinational); bn_in_data = in_data.
  - Each accepted sample increments pix.
  - On acceptance of sample PIXELS_PER_CH-1: pix returns to 0.
  - If ch<NUM_CHANNELS-1: ch increments, -> FETCH. Else -> DRAIN.
  - in_ready deasserts the cycle after the final accept.
- DRAIN: in_ready=0; wait until out_cnt == NUM_CHANNELS*PIXELS_PER_CH. -> DONE.
- DONE: done=1 for one cycle. -> IDLE.
- busy=1 in every state except IDLE.
- Output side is independent of the input-side state.
  - out_valid=bn_out_valid and out_data=bn_out_data, combinational pass-through.
  - out_ch/out_pix counters advance on bn_out_valid and wrap the same way as the input-side counters.
  - out_channel = out_ch.
  - out_last_pix = (out_pix==PIXELS_PER_CH-1).
  - out_last = out_last_pix & (out_ch==NUM_CHANNELS-1).
  - All three are qualified by out_valid; they are 0 when out_valid=0.
- The BN unit has no backpressure, so outputs are never stalled. Parameters stay constant for the entire STREAM state, including in_valid gaps.
- Overflow guard: bn_out_valid while out_cnt is already at its total is ignored (no counter wrap). Verification flags this as an error.

Decomposition:
- Package bn_seq_pkg: FSM state enum; param slice offsets MEAN_HI, VAR_HI, GAMMA_HI, BETA_HI.
- Single module. Output tagging counters are optionally a sub-module bn_out_tagger (out_ch/out_pix/out_cnt).

Test Plan:
- Bench config NUM_CHANNELS=2, PIXELS_PER_CH=4, BN_LATENCY=3.
- Single frame: start, in_valid constant high, ROM ch0={0,0x10,0x10,0}, ch1={0x20,0x10,0x10,0}.
  -> Params change only in LOAD cycles.
  -> in_ready low for exactly 2 cycles between channels.
  -> 8 out_valid pulses with out_channel 0,0,0,0,1,1,1,1.
  -> out_last on the 8th pulse; done 1 cycle after it.
- Bubbled input: in_valid toggles 1,0,1,0.
  -> pix advances only on accepted samples.
  -> bn_in_valid never high when in_valid=0.
  -> Parameters stable throughout.
- start asserted while busy -> no restart; ch/pix unaffected.
- Mid-frame reset after 3 accepted samples: assert rst.
  -> busy=0, in_ready=0, out_channel=0 immediately.
  -> A fresh start produces a full 8-output frame.
- Back-to-back frames: start asserted in the cycle after done.
  -> Second frame starts with FETCH of addr 0.
  -> out counters restarted at 0.
- Drain: stop in_valid after the final sample -> busy stays high for BN_LATENCY cycles, then done pulses once.
